// File: rtl/button_debouncer.sv
//------------------------------------------------------------------------------
// button_debouncer : push-button debouncer driving an external countdown timer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module button_debouncer #(
  parameter int ACTIVE_LOW  = 1,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   button_in,
  input  logic                   timer_done,
  input  logic                   count_clear,
  output logic                   timer_start,
  output logic                   timer_clear_n,
  output logic                   button_level,
  output logic                   press_pulse,
  output logic                   release_pulse,
  output logic [COUNT_WIDTH-1:0] press_count
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] c_one = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic                   w_btn_raw;
  logic                   w_btn_s;
  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic                   r_timer_start;
  logic                   r_timer_clear_n;
  logic                   r_button_level;
  logic                   r_press_pulse;
  logic                   r_release_pulse;
  logic [COUNT_WIDTH-1:0] r_press_count;

  // Polarity is normalised before synchronisation so btn_s is always 1 = pressed.
  generate
    if (ACTIVE_LOW != 0) begin : g_active_low
      assign w_btn_raw = ~button_in;
    end else begin : g_active_high
      assign w_btn_raw = button_in;
    end
  endgenerate

  assign w_btn_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_btn_raw};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= RELEASED;
      r_timer_start   <= 1'b0;
      r_timer_clear_n <= 1'b1;
      r_button_level  <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_press_count   <= '0;
    end else begin
      r_timer_start   <= 1'b0;
      r_timer_clear_n <= 1'b1;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;

      if (count_clear) begin
        r_press_count <= '0;
      end

      if (enable) begin
        case (r_state)
          RELEASED: begin
            if (w_btn_s) begin
              r_timer_start <= 1'b1;
              r_state       <= PRESS_WAIT;
            end
          end
          PRESS_WAIT: begin
            // A bounce beats a coincident timer_done.
            if (!w_btn_s) begin
              r_timer_clear_n <= 1'b0;
              r_state         <= RELEASED;
            end else if (timer_done) begin
              r_state        <= PRESSED;
              r_button_level <= 1'b1;
              r_press_pulse  <= 1'b1;
              if (!count_clear) begin
                r_press_count <= r_press_count + c_one;
              end
            end
          end
          PRESSED: begin
            if (!w_btn_s) begin
              r_timer_start <= 1'b1;
              r_state       <= RELEASE_WAIT;
            end
          end
          RELEASE_WAIT: begin
            if (w_btn_s) begin
              r_timer_clear_n <= 1'b0;
              r_state         <= PRESSED;
            end else if (timer_done) begin
              r_state         <= RELEASED;
              r_button_level  <= 1'b0;
              r_release_pulse <= 1'b1;
            end
          end
          default: r_state <= RELEASED;
        endcase
      end
    end
  end

  assign timer_start   = r_timer_start;
  assign timer_clear_n = r_timer_clear_n;
  assign button_level  = r_button_level;
  assign press_pulse   = r_press_pulse;
  assign release_pulse = r_release_pulse;
  assign press_count   = r_press_count;

endmodule

`default_nettype wire

// File: tb/tb_button_debouncer.sv
//------------------------------------------------------------------------------
// tb_button_debouncer : scoreboard bench with a countdown timer stub
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_button_debouncer;

  localparam logic [3:0] c_ev_start = 4'b1000;
  localparam logic [3:0] c_ev_clr   = 4'b0100;
  localparam logic [3:0] c_ev_press = 4'b0010;
  localparam logic [3:0] c_ev_rel   = 4'b0001;

  typedef struct {
    logic [3:0] ev;
    logic       level;
    logic [1:0] cnt;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       button_in;
  logic       timer_done;
  logic       count_clear;
  logic       timer_start;
  logic       timer_clear_n;
  logic       button_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [1:0] press_count;

  logic       r_stub_act;
  logic [3:0] r_stub_cnt;
  logic       stub_en;
  logic       force_done;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [1:0] m_cnt;
  exp_t       q[$];

  button_debouncer #(
    .ACTIVE_LOW (1),
    .SYNC_STAGES(2),
    .COUNT_WIDTH(2)
  ) dut (
    .clk          (clk),
    .reset        (rst),
    .enable       (enable),
    .button_in    (button_in),
    .timer_done   (timer_done),
    .count_clear  (count_clear),
    .timer_start  (timer_start),
    .timer_clear_n(timer_clear_n),
    .button_level (button_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_count  (press_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Timer stub: done is high for one cycle, 10 cycles after the start pulse.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stub_act <= 1'b0;
      r_stub_cnt <= '0;
    end else if (!timer_clear_n) begin
      r_stub_act <= 1'b0;
    end else if (enable) begin
      if (timer_start) begin
        r_stub_act <= 1'b1;
        r_stub_cnt <= 4'd9;
      end else if (r_stub_act) begin
        if (r_stub_cnt == 4'd0) r_stub_act <= 1'b0;
        else r_stub_cnt <= r_stub_cnt - 4'd1;
      end
    end
  end

  assign timer_done = (stub_en && r_stub_act && (r_stub_cnt == 4'd0)) || force_done;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp_v, cyc);
    end
  endtask

  // Any pulse on the DUT outputs must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [3:0] obs;
    exp_t       e;
    obs = {timer_start, ~timer_clear_n, press_pulse, release_pulse};
    if (!rst && obs != 4'b0000) begin
      if (q.size() == 0) begin
        check("unexpected_event", {28'd0, obs}, 32'd0);
      end else begin
        e = q.pop_front();
        check("event_kind", {28'd0, obs}, {28'd0, e.ev});
        check("event_cycle", cyc, e.cyc);
        check("event_level", {31'd0, button_level}, {31'd0, e.level});
        check("event_count", {30'd0, press_count}, {30'd0, e.cnt});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [3:0] ev, input logic lvl, input logic [1:0] cnt, input int c);
    exp_t e;
    e.ev = ev; e.level = lvl; e.cnt = cnt; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) tick();
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
    repeat (4) tick();
  endtask

  task automatic do_press(input logic clr);
    int e;
    button_in = 1'b0;
    e = cyc;
    push(c_ev_start, 1'b0, m_cnt, e + 3);
    m_cnt = clr ? 2'd0 : m_cnt + 2'd1;
    push(c_ev_press, 1'b1, m_cnt, e + 14);
    if (clr) begin
      while (cyc < e + 13) tick();
      count_clear = 1'b1;
      tick();
      count_clear = 1'b0;
    end
    drain();
  endtask

  task automatic do_release();
    int e;
    button_in = 1'b1;
    e = cyc;
    push(c_ev_start, 1'b1, m_cnt, e + 3);
    push(c_ev_rel, 1'b0, m_cnt, e + 14);
    drain();
  endtask

  initial begin
    int e;
    int x;
    rst = 1'b1; enable = 1'b1; button_in = 1'b1; count_clear = 1'b0;
    force_done = 1'b0; stub_en = 1'b1; m_cnt = 2'd0;
    repeat (2) tick();
    check("rst_level", {31'd0, button_level}, 32'd0);
    check("rst_press", {31'd0, press_pulse}, 32'd0);
    check("rst_release", {31'd0, release_pulse}, 32'd0);
    check("rst_start", {31'd0, timer_start}, 32'd0);
    check("rst_clear_n", {31'd0, timer_clear_n}, 32'd1);
    check("rst_count", {30'd0, press_count}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // Bounce during press wait: abort, no pulse.
    button_in = 1'b0;
    e = cyc;
    push(c_ev_start, 1'b0, m_cnt, e + 3);
    repeat (4) tick();
    button_in = 1'b1;
    push(c_ev_clr, 1'b0, m_cnt, e + 7);
    drain();
    repeat (12) tick();
    check("bounce_level", {31'd0, button_level}, 32'd0);

    // Bounce lands in the same cycle as timer_done.
    button_in = 1'b0;
    e = cyc;
    push(c_ev_start, 1'b0, m_cnt, e + 3);
    while (cyc < e + 11) tick();
    button_in = 1'b1;
    push(c_ev_clr, 1'b0, m_cnt, e + 14);
    drain();
    repeat (12) tick();
    check("coincide_count", {30'd0, press_count}, 32'd0);

    // Clean press/release, then wrap through 2-bit counter.
    do_press(1'b0);
    check("press_level", {31'd0, button_level}, 32'd1);
    do_release();
    check("release_level", {31'd0, button_level}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      do_press(1'b0);
      do_release();
    end
    check("wrap_count", {30'd0, press_count}, 32'd1);
    do_press(1'b1);
    check("clear_count", {30'd0, press_count}, 32'd0);
    do_release();

    // Enable low in PRESS_WAIT with done forced high: nothing moves.
    stub_en = 1'b0;
    button_in = 1'b0;
    e = cyc;
    push(c_ev_start, 1'b0, m_cnt, e + 3);
    while (cyc < e + 6) tick();
    enable = 1'b0;
    force_done = 1'b1;
    repeat (5) tick();
    check("hold_level", {31'd0, button_level}, 32'd0);
    check("hold_count", {30'd0, press_count}, {30'd0, m_cnt});
    enable = 1'b1;
    x = cyc;
    m_cnt = m_cnt + 2'd1;
    push(c_ev_press, 1'b1, m_cnt, x + 1);
    tick();
    force_done = 1'b0;
    drain();
    repeat (20) tick();
    stub_en = 1'b1;

    // Reset in RELEASE_WAIT takes effect immediately.
    button_in = 1'b1;
    e = cyc;
    push(c_ev_start, 1'b1, m_cnt, e + 3);
    while (cyc < e + 6) tick();
    #1 rst = 1'b1;
    #1;
    check("midrst_level", {31'd0, button_level}, 32'd0);
    check("midrst_count", {30'd0, press_count}, 32'd0);
    check("midrst_start", {31'd0, timer_start}, 32'd0);
    check("midrst_clear_n", {31'd0, timer_clear_n}, 32'd1);
    check("midrst_press", {31'd0, press_pulse}, 32'd0);
    check("midrst_release", {31'd0, release_pulse}, 32'd0);
    tick();
    rst = 1'b0;
    m_cnt = 2'd0;
    repeat (3) tick();

    do_press(1'b0);
    check("post_rst_count", {30'd0, press_count}, 32'd1);
    check("queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Debounces one raw push-button input.
- Drives an external countdown timer through a start pulse and an active-low synchronous clear, and consumes the timer's `done` indication.
- Sits directly upstream of the timer instance: `timer_start` feeds the timer `start` input, `timer_clear_n` feeds the timer `sync_resetn` input, and the timer `done` output returns as `timer_done`.
- Produces a clean level, one-cycle press/release pulses and a press counter for downstream game/control logic.

Parameters:
- ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed (the input is inverted before synchronisation); 0 = active-high.
- SYNC_STAGES, 2, number of flops in the input synchroniser chain; minimum 2.
- COUNT_WIDTH, 8, width of `press_count`.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  clock enable for the FSM and counter; the synchroniser always runs.
- button_in  input  1  raw, asynchronous, bouncing button.
- timer_done  input  1  from the timer `done` output; high for at least one cycle when the debounce interval expires.
- count_clear  input  1  synchronous clear of `press_count`.
- timer_start  output  1  one-cycle pulse to the timer `start` input.
- timer_clear_n  output  1  active-low, one-cycle pulse to the timer `sync_resetn` input; aborts the countdown.
- button_level  output  1  debounced level; 1 = pressed.
- press_pulse  output  1  one-cycle pulse on a debounced press.
- release_pulse  output  1  one-cycle pulse on a debounced release.
- press_count  output  COUNT_WIDTH  number of debounced presses; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset values:
  - synchroniser flops = 0 (released)
  - state = RELEASED
  - `button_level` = 0, `press_pulse` = 0, `release_pulse` = 0, `timer_start` = 0
  - `timer_clear_n` = 1
  - `press_count` = 0
- All outputs are registered; no combinational path from any input to any output.
- Synchroniser: `btn_s` = (ACTIVE_LOW ? ~button_in : button_in), delayed through SYNC_STAGES flops.
- FSM states and transitions (evaluated only when `enable` = 1):
  - RELEASED: `btn_s` = 1 -> assert `timer_start` next cycle; go to PRESS_WAIT.
  - PRESS_WAIT:
    - `btn_s` = 0 -> assert `timer_clear_n` = 0 next cycle; return to RELEASED (bounce, no pulse).
    - else `timer_done` = 1 -> go to PRESSED; `button_level` <= 1; `press_pulse` = 1 next cycle; `press_count` += 1.
  - PRESSED: `btn_s` = 0 -> assert `timer_start`; go to RELEASE_WAIT.
  - RELEASE_WAIT:
    - `btn_s` = 1 -> assert `timer_clear_n` = 0; return to PRESSED (no pulse).
    - else `timer_done` = 1 -> go to RELEASED; `button_level` <= 0; `release_pulse` = 1.
- `timer_done` is ignored in RELEASED and PRESSED.
- Simultaneous bounce and `timer_done` in a wait state: the bounce wins; abort path taken, no pulse.
- Pulses (`timer_start`, `timer_clear_n` low, `press_pulse`, `release_pulse`) last exactly one cycle, then return to idle values.
- `timer_start` and `timer_clear_n` = 0 are never asserted in the same cycle.
- Latency:
  - raw edge to `timer_start`: SYNC_STAGES + 1 cycles.
  - `timer_done` sampled to `press_pulse` / `button_level` change: 1 cycle.
- `enable` = 0:
  - state, `button_level` and `press_count` hold.
  - All pulse outputs forced idle (`timer_start` = 0, `timer_clear_n` = 1, press/release pulses 0).
  - A pending wait resumes when `enable` returns. The timer shares the same `enable`.
- `count_clear`:
  - has priority over increment; `press_count` = 0 next cycle regardless of `enable`.
  - a press on the same cycle is not counted, but `press_pulse` still fires.
- `press_count` wraps from 2^COUNT_WIDTH - 1 to 0 with no flag.
- Reset mid-wait: immediate return to reset values. The external timer is reset by the same system reset path.

Test Plan:
- Clean press, ACTIVE_LOW = 1, timer stub asserts `timer_done` 10 cycles after start, `button_in` 1 -> 0 held -> `timer_start` pulse 3 cycles after the edge; `press_pulse` 1 cycle after `timer_done`; `button_level` = 1; `press_count` = 1.
- Bounce on press: `button_in` low for 4 cycles then high before `timer_done` -> one `timer_clear_n` = 0 pulse; no `press_pulse`; state RELEASED; `press_count` unchanged at 0.
- Bounce and done coincide: `btn_s` returns to 0 in the same cycle `timer_done` = 1 -> abort; `press_pulse` stays 0; `timer_clear_n` pulses.
- Release path: from PRESSED, release held -> `timer_start`, then `release_pulse` 1 cycle after `timer_done`; `button_level` = 0; `press_count` unchanged.
- Wrap and clear, COUNT_WIDTH = 2: 5 clean presses -> `press_count` 1, 2, 3, 0, 1. Then `count_clear` on the same cycle as a 6th press -> `press_count` = 0 and `press_pulse` = 1.
- Enable and reset: `enable` = 0 during PRESS_WAIT with `timer_done` = 1 -> no transition and no pulses. Re-enable with `timer_done` = 1 -> `press_pulse`. Assert `reset` mid-wait -> all outputs at reset values within the same cycle.
